// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle slice-serial magnitude comparator with early exit
//
// Compares two WIDTH-bit operands one CHUNK-bit slice per clock, most
// significant slice first, and stops on the first slice that differs.
// Unsigned or two's-complement signed compare, selected per request.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, accepted only while idle
//   a, b         operands, captured on an accepted start
//   signed_mode  1 = two's-complement compare, captured on an accepted start
//   busy         high while a compare is in progress
//   done         one-cycle pulse when eq/lt/gt become valid
//   eq, lt, gt   result flags, held until the next accepted start

module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic [CHUNK-1:0] sign_flip;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             slice_ne;
    logic             last_slice;

    // The operand registers shift left by one slice per step, so the slice
    // under test always sits in the top CHUNK bits. In signed mode, flipping
    // the sign bit of the top slice maps two's-complement order onto unsigned
    // order; lower slices are plain magnitude bits.
    always_comb begin
        sign_flip  = (sm_q && (k_q == '0)) ? SIGN_MASK : '0;
        slice_a    = a_q[WIDTH-1 -: CHUNK] ^ sign_flip;
        slice_b    = b_q[WIDTH-1 -: CHUNK] ^ sign_flip;
        slice_ne   = (slice_a != slice_b);
        last_slice = (k_q == KW'(N - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPARE;
            COMPARE: if (slice_ne || last_slice) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == COMPARE);
        done = done_q;
        eq   = eq_q;
        lt   = lt_q;
        gt   = gt_q;
    end

    // Datapath next-state; done defaults low so it is a single-cycle pulse,
    // and a start taken in the done cycle clears it along with the flags.
    always_comb begin
        k_d    = k_q;
        a_d    = a_q;
        b_d    = b_q;
        sm_d   = sm_q;
        done_d = 1'b0;
        eq_d   = eq_q;
        lt_d   = lt_q;
        gt_d   = gt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d  = '0;
                    a_d  = a;
                    b_d  = b;
                    sm_d = signed_mode;
                    eq_d = 1'b0;
                    lt_d = 1'b0;
                    gt_d = 1'b0;
                end
            end
            COMPARE: begin
                if (slice_ne) begin
                    eq_d   = 1'b0;
                    lt_d   = (slice_a < slice_b);
                    gt_d   = (slice_a > slice_b);
                    done_d = 1'b1;
                end else if (last_slice) begin
                    eq_d   = 1'b1;
                    lt_d   = 1'b0;
                    gt_d   = 1'b0;
                    done_d = 1'b1;
                end else begin
                    k_d = k_q + KW'(1);
                    a_d = a_q << CHUNK;
                    b_d = b_q << CHUNK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sm_q   <= 1'b0;
            done_q <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            k_q    <= k_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sm_q   <= sm_d;
            done_q <= done_d;
            eq_q   <= eq_d;
            lt_q   <= lt_d;
            gt_q   <= gt_d;
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - self-checking bench for seq_magnitude_comparator

module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        sm_in = 1'b0;
    int          sel = 0;

    logic [2:0] start_v;
    logic [2:0] busy_v, done_v, eq_v, lt_v, gt_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign start_v[0] = start_in && (sel == 0);
    assign start_v[1] = start_in && (sel == 1);
    assign start_v[2] = start_in && (sel == 2);

    // sel 0: 16/4 (N=4), sel 1: 8/8 (N=1), sel 2: 32/4 (N=8)
    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_in[15:0]), .b(b_in[15:0]), .signed_mode(sm_in),
        .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .lt(lt_v[0]), .gt(gt_v[0]));

    seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_in[7:0]), .b(b_in[7:0]), .signed_mode(sm_in),
        .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .lt(lt_v[1]), .gt(gt_v[1]));

    seq_magnitude_comparator #(.WIDTH(32), .CHUNK(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_in), .b(b_in), .signed_mode(sm_in),
        .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]), .lt(lt_v[2]), .gt(gt_v[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sel_w(input int s);
        return (s == 0) ? 16 : (s == 1) ? 8 : 32;
    endfunction

    function automatic int sel_c(input int s);
        return (s == 1) ? 8 : 4;
    endfunction

    // Result code {eq,lt,gt} from integer arithmetic; latency from the
    // position of the highest differing bit.
    task automatic ref_cmp(input logic [31:0] a, input logic [31:0] b, input bit sm,
                           input int w, input int c,
                           output logic [2:0] res, output int lat);
        longint av, bv;
        logic [63:0] mask, x;
        int p;
        mask = (64'd1 << w) - 64'd1;
        av = longint'({32'd0, a} & mask);
        bv = longint'({32'd0, b} & mask);
        if (sm) begin
            if (av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
            if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
        end
        res = (av == bv) ? 3'b100 : (av < bv) ? 3'b010 : 3'b001;
        x = ({32'd0, a} ^ {32'd0, b}) & mask;
        p = -1;
        for (int i = 0; i < w; i++) if (x[i]) p = i;
        lat = (p < 0) ? (w / c) : ((w - 1 - p) / c + 1);
    endtask

    function automatic logic [2:0] res_of(input int s);
        return {eq_v[s], lt_v[s], gt_v[s]};
    endfunction

    task automatic wait_done(input int s, output int cyc);
        cyc = 0;
        while (!done_v[s] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_cmp(input logic [31:0] a, input logic [31:0] b, input bit sm, input int s);
        logic [2:0] exp_res;
        int exp_lat, cyc;
        ref_cmp(a, b, sm, sel_w(s), sel_c(s), exp_res, exp_lat);
        @(negedge clk);
        sel = s; a_in = a; b_in = b; sm_in = sm; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        a_in = $urandom; b_in = $urandom; sm_in = ~sm;
        check("busy_after_start", busy_v[s], 1);
        check("res_cleared", res_of(s), 3'b000);
        wait_done(s, cyc);
        check("latency", cyc, exp_lat);
        check("result", res_of(s), exp_res);
        check("onehot", $countones(res_of(s)), 1);
        @(posedge clk); #1;
        check("done_pulse_end", done_v[s], 0);
        check("idle_after", busy_v[s], 0);
        check("result_held", res_of(s), exp_res);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int cyc;

        #12;
        for (int s = 0; s < 3; s++) begin
            check("rst_busy", busy_v[s], 0);
            check("rst_done", done_v[s], 0);
            check("rst_res", res_of(s), 3'b000);
        end
        @(negedge clk); rst_n = 1'b1;

        // Directed
        do_cmp(32'hABCD, 32'hABCD, 0, 0);
        do_cmp(32'h8000, 32'h7FFF, 0, 0);
        do_cmp(32'h8000, 32'h7FFF, 1, 0);
        do_cmp(32'h1234, 32'h1235, 0, 0);
        do_cmp(32'h12F4, 32'h1204, 0, 0);
        do_cmp(32'hFFFE, 32'hFFFF, 1, 0);
        do_cmp(32'h0000, 32'hFFFF, 1, 0);
        do_cmp(32'h80, 32'h7F, 1, 1);
        do_cmp(32'h80, 32'h7F, 0, 1);
        do_cmp(32'h8000_0000, 32'h8000_0001, 1, 2);

        // start while busy is ignored
        @(negedge clk);
        sel = 0; a_in = 32'hABCD; b_in = 32'hABCD; sm_in = 0; start_in = 1'b1;
        @(posedge clk); #1;
        a_in = 32'h0000; b_in = 32'hFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_done(0, cyc);
        check("busy_ignore_lat", cyc, 2);
        check("busy_ignore_res", res_of(0), 3'b100);

        // start in the done cycle
        @(posedge clk); #1;
        a_in = 32'h1234; b_in = 32'h1235; sm_in = 0; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        wait_done(0, cyc);
        check("b2b_first_res", res_of(0), 3'b010);
        a_in = 32'h0000; b_in = 32'hFFFF; sm_in = 1; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        check("b2b_done_clr", done_v[0], 0);
        check("b2b_busy", busy_v[0], 1);
        check("b2b_res_clr", res_of(0), 3'b000);
        @(posedge clk); #1;
        check("b2b_done", done_v[0], 1);
        check("b2b_res", res_of(0), 3'b001);

        // reset mid-compare
        @(negedge clk);
        a_in = 32'hABCD; b_in = 32'hABCD; sm_in = 0; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_v[0], 0);
        check("midrst_done", done_v[0], 0);
        check("midrst_res", res_of(0), 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", done_v[0], 0);
        end
        @(negedge clk); rst_n = 1'b1;

        // Random regression: bias b toward a so later slices get exercised
        for (int i = 0; i < 4000; i++) begin
            int s;
            s = (i < 3000) ? 0 : (i < 3500) ? 1 : 2;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                default: rb = ra ^ (32'd1 << $urandom_range(0, sel_w(s) - 1));
            endcase
            do_cmp(ra, rb, 1'($urandom_range(0, 1)), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
